// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of an asynchronous square wave over a fixed
// gate window of GATE_CYCLES clocks (1 s at 50 MHz by default), so the result
// reads directly in Hz. Windows run back to back while En is high. Each
// completed window updates Freq_Out/Ovf together with a one-cycle Valid strobe.
// Optional feature: define FREQ_BCD_EN to add BCD_Out, a packed 8-digit BCD
// copy of the count that saturates at 0x99999999.
module freq_meter #(
   parameter int CLK_FREQ    = 50000000,
   parameter int GATE_CYCLES = CLK_FREQ,
   parameter int N_GATE      = 26,
   parameter int N_CNT       = 27
) (
   input  logic             CLK_50,
   input  logic             nRST,
   input  logic             En,
   input  logic             Sig_In,
   output logic [N_CNT-1:0] Freq_Out,
   output logic             Valid,
   output logic             Ovf
`ifdef FREQ_BCD_EN
   ,
   output logic [31:0]      BCD_Out
`endif
);

   typedef enum logic {IDLE, GATE} state_t;

   localparam logic [N_GATE-1:0] GATE_LAST = N_GATE'(GATE_CYCLES - 1);
   localparam logic [N_CNT-1:0]  CNT_MAX   = '1;

   state_t            state_reg, state_next;
   logic [2:0]        sync_reg;
   logic [N_GATE-1:0] gate_cnt_reg;
   logic [N_CNT-1:0]  edge_cnt_reg;
   logic              ovf_i_reg;
   logic [N_CNT-1:0]  freq_reg;
   logic              valid_reg;
   logic              ovf_reg;

   logic              rise;
   logic              terminal;
   logic              counting;
   logic              edge_sat;
   logic [N_CNT-1:0]  edge_next;
   logic              ovf_next;

   // Three-flop chain: two stages against metastability, the third to find the edge
   always_ff @(posedge CLK_50 or negedge nRST) begin
      if (!nRST) begin
         sync_reg <= 3'b000;
      end else begin
         sync_reg <= {sync_reg[1:0], Sig_In};
      end
   end

   assign rise      = sync_reg[1] & ~sync_reg[2];
   assign terminal  = (state_reg == GATE) && (gate_cnt_reg == GATE_LAST);
   assign counting  = (state_reg == GATE) && !terminal && En;
   assign edge_sat  = (edge_cnt_reg == CNT_MAX);
   assign edge_next = (rise && !edge_sat) ? edge_cnt_reg + 1'b1 : edge_cnt_reg;
   assign ovf_next  = ovf_i_reg | (rise & edge_sat);

   // State register
   always_ff @(posedge CLK_50 or negedge nRST) begin
      if (!nRST) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next state: a terminal cycle always completes before En is honoured
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (En) begin
               state_next = GATE;
            end
         end
         GATE: begin
            if (!En) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Gate/edge counting and result latch; anything other than an ongoing window clears the counters
   always_ff @(posedge CLK_50 or negedge nRST) begin
      if (!nRST) begin
         gate_cnt_reg <= '0;
         edge_cnt_reg <= '0;
         ovf_i_reg    <= 1'b0;
         freq_reg     <= '0;
         valid_reg    <= 1'b0;
         ovf_reg      <= 1'b0;
      end else begin
         valid_reg <= 1'b0;
         if (counting) begin
            gate_cnt_reg <= gate_cnt_reg + 1'b1;
            edge_cnt_reg <= edge_next;
            ovf_i_reg    <= ovf_next;
         end else begin
            gate_cnt_reg <= '0;
            edge_cnt_reg <= '0;
            ovf_i_reg    <= 1'b0;
         end
         if (terminal) begin
            freq_reg  <= edge_next;
            ovf_reg   <= ovf_next;
            valid_reg <= 1'b1;
         end
      end
   end

   assign Freq_Out = freq_reg;
   assign Valid    = valid_reg;
   assign Ovf      = ovf_reg;

`ifdef FREQ_BCD_EN
   logic [31:0] bcd_cnt_reg;
   logic [31:0] bcd_out_reg;
   logic [31:0] bcd_inc;
   logic [31:0] bcd_next;
   logic [8:0]  carry;

   // Decimal ripple increment; carry[8] high means all digits are 9
   assign carry[0] = 1'b1;
   for (genvar gi = 0; gi < 8; gi++) begin : g_digit
      logic nine;
      assign nine             = (bcd_cnt_reg[4*gi +: 4] == 4'd9);
      assign bcd_inc[4*gi +: 4] = carry[gi] ? (nine ? 4'd0 : bcd_cnt_reg[4*gi +: 4] + 4'd1)
                                            : bcd_cnt_reg[4*gi +: 4];
      assign carry[gi+1]      = carry[gi] & nine;
   end

   assign bcd_next = (rise && !carry[8]) ? bcd_inc : bcd_cnt_reg;

   // BCD counter follows edge_cnt: same clear, same latch edge
   always_ff @(posedge CLK_50 or negedge nRST) begin
      if (!nRST) begin
         bcd_cnt_reg <= '0;
         bcd_out_reg <= '0;
      end else begin
         if (counting) begin
            bcd_cnt_reg <= bcd_next;
         end else begin
            bcd_cnt_reg <= '0;
         end
         if (terminal) begin
            bcd_out_reg <= bcd_next;
         end
      end
   end

   assign BCD_Out = bcd_out_reg;
`endif

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: drives two freq_meter instances (27-bit and 4-bit result)
// with directed and random square waves and checks every cycle against a
// window-level model: rises of the sampled input, seen two clocks late,
// summed over GATE_CYCLES-edge windows that start one edge after En is seen.
module tb_freq_meter;

   localparam int G = 100;

   logic        clk  = 1'b0;
   logic        nrst = 1'b1;
   logic        en   = 1'b0;
   logic        sig  = 1'b0;
   logic [26:0] freq;
   logic        valid, ovf;
   logic [3:0]  freq_s;
   logic        valid_s, ovf_s;
`ifdef FREQ_BCD_EN
   logic [31:0] bcd, bcd_s;
`endif

   always #10 clk = ~clk;

   freq_meter #(.GATE_CYCLES(G), .N_GATE(26), .N_CNT(27)) dut (
      .CLK_50(clk), .nRST(nrst), .En(en), .Sig_In(sig),
      .Freq_Out(freq), .Valid(valid), .Ovf(ovf)
`ifdef FREQ_BCD_EN
      , .BCD_Out(bcd)
`endif
   );

   freq_meter #(.GATE_CYCLES(G), .N_GATE(7), .N_CNT(4)) dut_small (
      .CLK_50(clk), .nRST(nrst), .En(en), .Sig_In(sig),
      .Freq_Out(freq_s), .Valid(valid_s), .Ovf(ovf_s)
`ifdef FREQ_BCD_EN
      , .BCD_Out(bcd_s)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model state
   bit x_hist[$];
   bit m_gate;
   int m_pos, m_cnt;
   int exp_freq, exp_freq_s;
   bit exp_ovf_s, exp_valid;
   int n_valid;

`ifdef FREQ_BCD_EN
   function automatic logic [31:0] to_bcd(input int v);
      logic [31:0] r;
      int t;
      r = '0;
      t = (v > 99999999) ? 99999999 : v;
      for (int i = 0; i < 8; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction
   logic [31:0] exp_bcd;
`endif

   task automatic model_reset();
      x_hist = {};
      repeat (3) x_hist.push_back(1'b0);
      m_gate = 0; m_pos = 0; m_cnt = 0;
      exp_freq = 0; exp_freq_s = 0; exp_ovf_s = 0; exp_valid = 0;
`ifdef FREQ_BCD_EN
      exp_bcd = '0;
`endif
   endtask

   task automatic check_outputs(input string ph);
      check({ph, ".valid"},   valid,   exp_valid);
      check({ph, ".freq"},    freq,    exp_freq);
      check({ph, ".ovf"},     ovf,     0);
      check({ph, ".valid_s"}, valid_s, exp_valid);
      check({ph, ".freq_s"},  freq_s,  exp_freq_s);
      check({ph, ".ovf_s"},   ovf_s,   exp_ovf_s);
`ifdef FREQ_BCD_EN
      check({ph, ".bcd"},     bcd,     exp_bcd);
      check({ph, ".bcd_s"},   bcd_s,   exp_bcd);
`endif
   endtask

   // One clock: called at a negedge, drives inputs, advances the model, checks, returns at the next negedge
   task automatic step(input bit e, input bit s);
      bit r;
      en  = e;
      sig = s;
      @(posedge clk);
      r = x_hist[$-1] & ~x_hist[$-2];
      x_hist.push_back(s);
      if (x_hist.size() > 8) void'(x_hist.pop_front());
      exp_valid = 0;
      if (m_gate) begin
         m_pos++;
         m_cnt += int'(r);
         if (m_pos == G) begin
            exp_valid  = 1;
            exp_freq   = m_cnt;
            exp_freq_s = (m_cnt > 15) ? 15 : m_cnt;
            exp_ovf_s  = (m_cnt > 15);
`ifdef FREQ_BCD_EN
            exp_bcd    = to_bcd(m_cnt);
`endif
            n_valid++;
            m_cnt  = 0;
            m_pos  = 0;
            m_gate = e;
         end else if (!e) begin
            m_gate = 0; m_cnt = 0; m_pos = 0;
         end
      end else if (e) begin
         m_gate = 1; m_pos = 0; m_cnt = 0;
      end
      #1;
      check_outputs("cyc");
      @(negedge clk);
   endtask

   task automatic run_wave(input int n, input int p, input int h, input bit e);
      for (int t = 0; t < n; t++) step(e, bit'((t % p) < h));
   endtask

   // Asynchronous reset pulse between edges; outputs must clear without a clock
   task automatic do_reset();
      #3 nrst = 1'b0;
      #1;
      check("rst.freq",  freq,  0);
      check("rst.valid", valid, 0);
      check("rst.ovf",   ovf,   0);
      check("rst.freq_s", freq_s, 0);
      check("rst.ovf_s",  ovf_s,  0);
      @(negedge clk);
      nrst = 1'b1;
      model_reset();
   endtask

   initial begin
      int v0;
      model_reset();
      n_valid = 0;
      @(negedge clk);
      do_reset();

      // Period 10: count 10 per window
      run_wave(320, 10, 5, 1);
      check("t1.last_freq", freq, 10);
      run_wave(5, 10, 5, 0);

      // Held low, then held high: a single count in the stepping window
      run_wave(150, 1, 0, 1);
      run_wave(250, 1, 1, 1);
      run_wave(5, 1, 1, 0);

      // Toggle every clock (50, saturates the 4-bit instance), then period 10
      run_wave(205, 2, 1, 1);
      check("t3.freq50", freq, 50);
      check("t3.ovf_s",  ovf_s, 1);
      run_wave(200, 10, 5, 1);
      check("t3.ovf_s_clr", ovf_s, 0);
      run_wave(5, 10, 5, 0);

      // En drop after 250 cycles: exactly two windows complete
      v0 = n_valid;
      run_wave(250, 10, 5, 1);
      run_wave(150, 10, 5, 0);
      check("t4.valid_cnt", n_valid - v0, 2);
      run_wave(150, 10, 5, 1);
      run_wave(5, 10, 5, 0);

      // En dropped exactly on the terminal cycle: result still published
      v0 = n_valid;
      run_wave(G, 7, 3, 1);
      run_wave(30, 7, 3, 0);
      check("term_drop.valid_cnt", n_valid - v0, 1);

      // Reset in the middle of a window
      run_wave(160, 10, 5, 1);
      do_reset();
      run_wave(220, 10, 5, 1);

      // Random segments: random period/duty, occasional En drops and resets
      for (int seg = 0; seg < 40; seg++) begin
         int p, h, n, mode;
         bit e;
         p    = $urandom_range(2, 40);
         h    = $urandom_range(1, p - 1);
         n    = $urandom_range(30, 260);
         e    = ($urandom_range(0, 9) != 0);
         mode = $urandom_range(0, 7);
         if (mode == 0) begin
            for (int t = 0; t < n; t++) step(e, bit'($urandom_range(0, 1)));
         end else if (mode == 1) begin
            do_reset();
            run_wave(n, p, h, e);
         end else begin
            run_wave(n, p, h, e);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Measures the frequency of an external square wave `Sig_In` against the 50 MHz system clock.
- Uses a fixed gate window, default 1 s, so the count equals Hz directly.
- Counterpart to the divider blocks: they generate 1 Hz–1 kHz from 50 MHz; this block measures such a signal back.
- Feeds display/debug logic; results are a binary word plus a one-cycle `Valid` strobe.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz (documentation/derivation only).
- GATE_CYCLES, 50000000, gate window length in CLK_50 cycles (1 s at 50 MHz).
- N_GATE, 26, gate counter width; must satisfy 2^N_GATE > GATE_CYCLES.
- N_CNT, 27, edge counter and result width.

Ports:
- CLK_50  input  1  system clock, 50 MHz, all logic on posedge.
- nRST  input  1  asynchronous active-low reset.
- En  input  1  measurement enable, synchronous, level.
- Sig_In  input  1  asynchronous signal under measurement.
- Freq_Out  output  N_CNT  rising edges counted in the last completed window.
- Valid  output  1  one-cycle pulse; Freq_Out/Ovf updated this cycle.
- Ovf  output  1  last completed window saturated the edge counter.

Behaviour:
- Reset (nRST=0, async):
  - state=IDLE, gate_cnt=0, edge_cnt=0.
  - Sync flops s1/s2/s3=0.
  - Freq_Out=0, Valid=0, Ovf=0.
- Input sync: Sig_In→s1→s2→s3 every cycle regardless of state. rise = s2 & ~s3. Latency from Sig_In edge to rise = 2–3 cycles.
- FSM states: IDLE, GATE.
- IDLE:
  - gate_cnt=0, edge_cnt=0, Valid=0; Freq_Out/Ovf hold.
  - En=1 → GATE next cycle.
- GATE:
  - Each cycle, gate_cnt+1.
  - If rise, edge_cnt+1, saturating at 2^N_CNT-1; saturation sets internal ovf_i.
  - Terminal cycle is gate_cnt==GATE_CYCLES-1. At the following clock edge:
    - Freq_Out <= edge_cnt + rise (saturated); Ovf <= ovf_i (or saturation this cycle).
    - Valid <= 1 for exactly one cycle.
    - gate_cnt, edge_cnt, ovf_i <= 0; remain in GATE.
  - Windows are back-to-back with no dead time. Every rise is counted in exactly one window.
- En deasserted in GATE:
  - Next edge → IDLE; partial window discarded; no Valid; Freq_Out/Ovf hold.
  - If En drops on the terminal cycle, the terminal update wins: Valid pulses, then IDLE.
- First window after IDLE→GATE starts with gate_cnt=0. The first Valid comes GATE_CYCLES cycles after entering GATE.
- Measurable range: 0 to CLK_FREQ/2 per gate-second. Faster inputs alias; this is not detected.
- Resolution: ±1 count (gate/edge phase).
- Reset mid-window: all state cleared as above; no Valid.

Optional Feature:
- FREQ_BCD_EN defined:
  - Adds output BCD_Out [31:0]: 8 decade counters, digit0 = LSD.
  - Counters increment on rise in parallel with edge_cnt and carry each 9→0.
  - Latched into BCD_Out on the same edge as Freq_Out; cleared with edge_cnt.
  - On overflow past 99999999, BCD_Out saturates at 0x99999999.
  - Reset value 0.
- Not defined: port absent; no BCD logic.

Test Plan (GATE_CYCLES=100 unless stated):
1. En=1, Sig_In period 10 clk (5 high/5 low) → Valid every 100 cycles; Freq_Out=10, Ovf=0 from the second window on.
2. En=1, Sig_In held 0, then held 1 → Freq_Out=0 on each Valid, except 1 in the window containing the 0→1 step.
3. En=1, Sig_In toggling every clk (period 2) → Freq_Out=50. With N_CNT=4: Freq_Out=15, Ovf=1. Next window with period 10 → Freq_Out=10, Ovf=0.
4. En=1, period 10 for 250 cycles, then En=0 at cycle 250 → exactly 2 Valid pulses; Freq_Out stays 10 with no further Valid. En=1 again → first Valid 100 cycles after the GATE re-entry edge.
5. nRST pulsed low mid-window (cycle 60) → all outputs 0 immediately; with En=1 on release, next Valid 100 cycles later with correct count.
6. FREQ_BCD_EN, GATE_CYCLES=1000, Sig_In period 8 → Freq_Out=125, BCD_Out=0x00000125.
